// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory.
// Optional busy watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_write,
  input  logic              p0_req,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_write,
  input  logic              p1_req,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_done,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_owner;
  logic   w_owner_next;
  logic   r_last_owner;
  logic   w_last_owner_next;
  logic   w_timeout;

  // last_owner starts at 1 so that port 0 wins the first tie after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_owner <= w_last_owner_next;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Counts cycles spent in the current BUSY visit; zero on the first BUSY cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == S_BUSY && w_state_next == S_BUSY) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= '0;
    end
  end

  assign w_timeout = (r_state == S_BUSY) && (r_count == CNT_W'(TIMEOUT_CYCLES));
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_owner_next = r_last_owner;
    mem_req           = 1'b0;
    mem_write         = 1'b0;
    mem_addr          = '0;
    mem_data_in       = '0;
    grant             = 2'b00;
    p0_done           = 1'b0;
    p1_done           = 1'b0;
    p0_err            = 1'b0;
    p1_err            = 1'b0;
    p0_rdata          = '0;
    p1_rdata          = '0;

    case (r_state)
      S_IDLE: begin
        if (p0_req && p1_req) begin
          w_owner_next = ~r_last_owner;
          w_state_next = S_BUSY;
        end else if (p0_req) begin
          w_owner_next = 1'b0;
          w_state_next = S_BUSY;
        end else if (p1_req) begin
          w_owner_next = 1'b1;
          w_state_next = S_BUSY;
        end
      end

      S_BUSY: begin
        mem_req     = 1'b1;
        mem_addr    = r_owner ? p1_addr  : p0_addr;
        mem_data_in = r_owner ? p1_wdata : p0_wdata;
        mem_write   = r_owner ? p1_write : p0_write;
        grant       = r_owner ? 2'b10 : 2'b01;
        // A real completion takes precedence over a watchdog expiry in the same cycle.
        if (mem_done) begin
          if (r_owner) begin
            p1_done  = 1'b1;
            p1_rdata = mem_data_out;
          end else begin
            p0_done  = 1'b1;
            p0_rdata = mem_data_out;
          end
          w_last_owner_next = r_owner;
          w_state_next      = S_RELEASE;
        end else if (w_timeout) begin
          if (r_owner) begin
            p1_done = 1'b1;
            p1_err  = 1'b1;
          end else begin
            p0_done = 1'b1;
            p0_err  = 1'b1;
          end
          w_last_owner_next = r_owner;
          w_state_next      = S_RELEASE;
        end
      end

      S_RELEASE: begin
        grant        = r_owner ? 2'b10 : 2'b01;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; completions are checked against a scoreboard
// queue filled whenever the bench drives a mem_done that should complete.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int TO     = 4;

  logic              clock;
  logic              reset;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_write, p1_write, p0_req, p1_req;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              p0_done, p1_done, p0_err, p1_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              mem_write, mem_req, mem_done;
  logic [1:0]        grant;

  typedef struct {
    logic             port;
    logic [DATA_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_write(p0_write), .p0_req(p0_req),
    .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_write(p1_write), .p1_req(p1_req),
    .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write(mem_write),
    .mem_req(mem_req), .mem_data_out(mem_data_out), .mem_done(mem_done),
    .grant(grant)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic samp();
    @(negedge clock);
  endtask

  task automatic push(input logic port, input logic [DATA_W-1:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.data = data;
    e.err  = err;
    q.push_back(e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_grant"}, {30'd0, grant}, 32'd0);
  endtask

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    logic             d [2];
    logic             er[2];
    logic [DATA_W-1:0] rd[2];
    exp_t e;
    d[0] = p0_done;  d[1] = p1_done;
    er[0] = p0_err;  er[1] = p1_err;
    rd[0] = p0_rdata; rd[1] = p1_rdata;
    for (int p = 0; p < 2; p++) begin
      if (d[p] === 1'b1) begin
        if (q.size() == 0) begin
          chk($sformatf("spurious_done_p%0d", p), {31'd0, d[p]}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_port", p, {31'd0, e.port});
          chk($sformatf("rdata_p%0d", p), {24'd0, rd[p]}, {24'd0, e.data});
          chk($sformatf("err_p%0d", p), {31'd0, er[p]}, {31'd0, e.err});
          $display("[TB] done p%0d rdata=%02h err=%0b", p, rd[p], er[p]);
        end
      end else begin
        chk($sformatf("quiet_rdata_p%0d", p), {24'd0, rd[p]}, 32'd0);
        chk($sformatf("quiet_err_p%0d", p), {31'd0, er[p]}, 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    p0_addr = '0; p0_wdata = '0; p0_write = 1'b0; p0_req = 1'b0;
    p1_addr = '0; p1_wdata = '0; p1_write = 1'b0; p1_req = 1'b0;
    mem_data_out = '0; mem_done = 1'b0;

    // Reset state, with requests and mem_done active to prove outputs are forced low.
    p0_req = 1'b1; mem_done = 1'b1;
    samp();
    chk_idle("reset");
    step();
    p0_req = 1'b0; mem_done = 1'b0; reset = 1'b0;

    // p0 write 0x0010/0xA5, completion on cycle 3.
    p0_req = 1'b1; p0_write = 1'b1; p0_addr = 16'h0010; p0_wdata = 8'hA5;
    samp(); chk_idle("wr_c0");
    step();
    samp();
    chk("wr_c1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("wr_c1_mem_write", {31'd0, mem_write}, 32'd1);
    chk("wr_c1_mem_addr", {16'd0, mem_addr}, 32'h0010);
    chk("wr_c1_mem_data", {24'd0, mem_data_in}, 32'hA5);
    chk("wr_c1_grant", {30'd0, grant}, 32'd1);
    step();
    samp(); chk("wr_c2_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    mem_done = 1'b1; push(1'b0, 8'h00, 1'b0);
    samp(); chk("wr_c3_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    mem_done = 1'b0; p0_req = 1'b0; p0_write = 1'b0;
    samp();
    chk("wr_c4_release_mem_req", {31'd0, mem_req}, 32'd0);
    chk("wr_c4_release_grant", {30'd0, grant}, 32'd1);
    step();
    samp(); chk_idle("wr_c5");
    $display("[TB] p0 write 0010 done");

    // p1 read 0x00FF returning 0x3C.
    step();
    p1_req = 1'b1; p1_addr = 16'h00FF;
    samp();
    step();
    mem_done = 1'b1; mem_data_out = 8'h3C; push(1'b1, 8'h3C, 1'b0);
    samp();
    chk("rd_grant", {30'd0, grant}, 32'd2);
    chk("rd_mem_addr", {16'd0, mem_addr}, 32'h00FF);
    chk("rd_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    mem_done = 1'b0; mem_data_out = 8'h77; p1_req = 1'b0;
    samp(); chk("rd_release_grant", {30'd0, grant}, 32'd2);
    step();
    samp(); chk_idle("rd_idle");
    $display("[TB] p1 read 00FF done");

    // Stray mem_done in IDLE with no requests.
    mem_done = 1'b1;
    samp(); chk_idle("stray_idle");
    step();
    mem_done = 1'b0;

    // Fresh reset, then a held tie: grants alternate p0,p1,p0,p1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1; p0_addr = 16'h0100; p1_addr = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      logic exp_port;
      exp_port = k[0];
      samp(); chk_idle($sformatf("tie%0d_idle", k));
      step();
      mem_done = 1'b1; mem_data_out = 8'h10 + 8'(k); push(exp_port, 8'h10 + 8'(k), 1'b0);
      samp();
      chk($sformatf("tie%0d_grant", k), {30'd0, grant}, exp_port ? 32'd2 : 32'd1);
      chk($sformatf("tie%0d_mem_addr", k), {16'd0, mem_addr}, exp_port ? 32'h0200 : 32'h0100);
      step();
      mem_done = 1'b0;
      samp();
      chk($sformatf("tie%0d_release_mem_req", k), {31'd0, mem_req}, 32'd0);
      chk($sformatf("tie%0d_release_grant", k), {30'd0, grant}, exp_port ? 32'd2 : 32'd1);
      step();
      $display("[TB] tie grant %0d to p%0d", k, exp_port);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    samp(); chk_idle("tie_end");
    step();

    // Owner drops its request mid-access; the access still completes.
    p0_req = 1'b1; p0_addr = 16'h0300;
    samp();
    step();
    p0_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      samp(); chk($sformatf("drop%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
      step();
    end
    mem_done = 1'b1; mem_data_out = 8'h99; push(1'b0, 8'h99, 1'b0);
    samp();
    step();
    mem_done = 1'b0;
    samp();
    step();
    $display("[TB] dropped-request access completed");

    // Reset asserted mid-BUSY abandons the access.
    p1_req = 1'b1; p1_addr = 16'h0400;
    samp();
    step();
    samp(); chk("rst_busy_grant", {30'd0, grant}, 32'd2);
    reset = 1'b1;
    #1;
    chk_idle("rst_async");
    mem_done = 1'b1;
    step();
    reset = 1'b0; p1_req = 1'b0;
    samp(); chk_idle("rst_after");
    step();
    mem_done = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    samp();
    step();
    mem_done = 1'b1; mem_data_out = 8'h42; push(1'b0, 8'h42, 1'b0);
    samp(); chk("rst_next_grant", {30'd0, grant}, 32'd1);
    step();
    mem_done = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    samp();
    step();
    $display("[TB] reset mid-busy handled");

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog expiry: done+err four cycles after mem_req rises.
    p0_req = 1'b1; p0_addr = 16'h0500;
    samp();
    step();
    for (int k = 1; k <= TO; k++) begin
      samp(); chk($sformatf("to_c%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
      step();
    end
    push(1'b0, 8'h00, 1'b1);
    mem_data_out = 8'hEE;
    samp(); chk("to_expire_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    p0_req = 1'b0; mem_done = 1'b1;
    samp(); chk("to_release_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    samp(); chk_idle("to_stray_idle");
    step();
    mem_done = 1'b0;
    $display("[TB] timeout pulse observed");

    // mem_done on the expiry cycle wins over the watchdog.
    p0_req = 1'b1;
    samp();
    step();
    for (int k = 1; k <= TO; k++) begin
      samp();
      step();
    end
    mem_done = 1'b1; mem_data_out = 8'h5A; push(1'b0, 8'h5A, 1'b0);
    samp();
    step();
    mem_done = 1'b0; p0_req = 1'b0;
    samp(); chk("race_release_grant", {30'd0, grant}, 32'd1);
    step();
    $display("[TB] done beats timeout");
`else
    // Without the watchdog BUSY persists indefinitely with no error.
    p0_req = 1'b1; p0_addr = 16'h0500;
    samp();
    step();
    for (int k = 1; k <= 20; k++) begin
      samp();
      chk($sformatf("nto_c%0d_mem_req", k), {31'd0, mem_req}, 32'd1);
      chk($sformatf("nto_c%0d_err", k), {31'd0, p0_err}, 32'd0);
      step();
    end
    mem_done = 1'b1; mem_data_out = 8'h5A; push(1'b0, 8'h5A, 1'b0);
    samp();
    step();
    mem_done = 1'b0; p0_req = 1'b0;
    samp();
    step();
    $display("[TB] no-timeout build waited for mem_done");
`endif

    samp();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
